// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, PRId value, SR/Cause field positions,
// ExcCode values and the exception-level state encoding.
package cp0_pkg;

   localparam logic [4:0]  REG_SR     = 5'd12;
   localparam logic [4:0]  REG_CAUSE  = 5'd13;
   localparam logic [4:0]  REG_EPC    = 5'd14;
   localparam logic [4:0]  REG_PRID   = 5'd15;
   localparam logic [31:0] PRID_VALUE = 32'h4C59_0001;

   localparam int SR_IE_BIT     = 0;
   localparam int SR_EXL_BIT    = 1;
   localparam int SR_IM_LSB     = 10;
   localparam int CAUSE_EXC_LSB = 2;
   localparam int CAUSE_IP_LSB  = 10;
   localparam int CAUSE_BD_BIT  = 31;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   typedef enum logic {
      ST_NORMAL  = 1'b0,
      ST_HANDLER = 1'b1
   } cp0_state_e;

endpackage

// File: rtl/cp0_exc_prio.sv
// Decides whether the M-stage instruction traps this cycle and with which ExcCode;
// a pending interrupt outranks a synchronous exception.
module cp0_exc_prio
   import cp0_pkg::*;
(
   input  logic [5:0] hw_int,
   input  logic [5:0] im,
   input  logic       ie,
   input  logic       exl,
   input  logic       m_valid,
   input  logic       exc_m,
   input  logic [4:0] exc_code_m,
   output logic       take,
   output logic [4:0] take_code
);

   logic int_pend;

   assign int_pend  = (|(hw_int & im)) & ie & ~exl;
   assign take      = m_valid & ~exl & (int_pend | exc_m);
   assign take_code = int_pend ? EXC_INT : exc_code_m;

endmodule

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 control: SR/Cause/EPC/PRId, exception entry and eret, mtc0/mfc0 access.
module cp0_ctrl
   import cp0_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  hw_int,
   input  logic        m_valid,
   input  logic [31:0] pc_m,
   input  logic        bd_m,
   input  logic        exc_m,
   input  logic [4:0]  exc_code_m,
   input  logic        eret_m,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [4:0]  raddr,
   input  logic [31:0] wdata,
   output logic        int_req,
   output logic [31:0] epc,
   output logic [31:0] rdata,
   output logic        exl
);

   cp0_state_e  state;
   logic [5:0]  im;
   logic        ie;
   logic [5:0]  ip;
   logic [4:0]  exc_code;
   logic        bd;
   logic [31:0] epc_q;
   logic        take;
   logic [4:0]  take_code;
   logic        wr_sr;
   logic        wr_epc;

   assign exl    = state;
   assign epc    = epc_q;
   assign wr_sr  = we && (waddr == REG_SR);
   assign wr_epc = we && (waddr == REG_EPC);

   cp0_exc_prio u_prio (
      .hw_int     (hw_int),
      .im         (im),
      .ie         (ie),
      .exl        (exl),
      .m_valid    (m_valid),
      .exc_m      (exc_m),
      .exc_code_m (exc_code_m),
      .take       (take),
      .take_code  (take_code)
   );

   // Suppressed during reset so a trapping M-stage op cannot flush while held in reset.
   assign int_req = take & reset;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_NORMAL;
         im       <= '0;
         ie       <= 1'b0;
         ip       <= '0;
         exc_code <= '0;
         bd       <= 1'b0;
         epc_q    <= '0;
      end else begin
         ip <= hw_int;
         if (wr_sr) begin
            im <= wdata[SR_IM_LSB +: 6];
            ie <= wdata[SR_IE_BIT];
         end
         // Exception entry owns EXL/EPC/Cause; otherwise mtc0 beats eret for EXL.
         if (take) begin
            state    <= ST_HANDLER;
            exc_code <= take_code;
            bd       <= bd_m;
            epc_q    <= bd_m ? (pc_m - 32'd4) : pc_m;
         end else begin
            if (wr_sr)
               state <= wdata[SR_EXL_BIT] ? ST_HANDLER : ST_NORMAL;
            else if (eret_m && m_valid && state == ST_HANDLER)
               state <= ST_NORMAL;
            if (wr_epc)
               epc_q <= {wdata[31:2], 2'b00};
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (raddr)
         REG_SR: begin
            rdata[SR_IM_LSB +: 6] = im;
            rdata[SR_EXL_BIT]     = exl;
            rdata[SR_IE_BIT]      = ie;
         end
         REG_CAUSE: begin
            rdata[CAUSE_BD_BIT]        = bd;
            rdata[CAUSE_IP_LSB +: 6]   = ip;
            rdata[CAUSE_EXC_LSB +: 5]  = exc_code;
         end
         REG_EPC:  rdata = epc_q;
         REG_PRID: rdata = PRID_VALUE;
         default:  rdata = '0;
      endcase
   end

endmodule

// File: doc/cp0_ctrl.md
CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 clk  in  1  sole clock, all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-003 hw_int  in  6  external interrupt lines; level-sensitive, sampled each cycle.
REQ-004 m_valid  in  1  M-stage holds a real instruction (not a bubble).
REQ-005 pc_m  in  32  PC of the M-stage instruction.
REQ-006 bd_m  in  1  M-stage instruction sits in a branch delay slot.
REQ-007 exc_m  in  1  synchronous exception raised by the M-stage instruction.
REQ-008 exc_code_m  in  5  ExcCode for exc_m.
REQ-009 eret_m  in  1  M-stage instruction is eret.
REQ-010 we  in  1  mtc0 write strobe.
REQ-011 waddr, raddr  in  5 each  CP0 register number for write and read.
REQ-012 wdata  in  32  mtc0 write data.
REQ-013 int_req  out  1  exception/interrupt taken this cycle; drives fetch-unit IntReq and pipeline flush.
REQ-014 epc  out  32  current EPC; drives fetch-unit eret target.
REQ-015 rdata  out  32  mfc0 read data, combinational from raddr.
REQ-016 exl  out  1  handler-active flag (SR.EXL).

Function
REQ-017 Registers: SR(12) = IM[15:10], EXL[1], IE[0], other bits read 0; Cause(13) = BD[31], IP[15:10], ExcCode[6:2], other bits 0; EPC(14) 32 bits; PRId(15) constant 32'h4C59_0001.
REQ-018 Cause.IP SHALL be loaded with hw_int every cycle, independent of other writes.
REQ-019 int_pend = |(hw_int & SR.IM) & SR.IE & ~SR.EXL, combinational.
REQ-020 int_req = m_valid & ~SR.EXL & (int_pend | exc_m), combinational, same cycle.
REQ-021 Priority: interrupt over synchronous exception; interrupt SHALL record ExcCode 0, otherwise exc_code_m.
REQ-022 On int_req edge: EXL<=1; Cause.ExcCode per REQ-021; Cause.BD<=bd_m; EPC<=bd_m ? pc_m-4 : pc_m (32-bit wrap, 0x0000_0000-4 = 0xFFFF_FFFC).
REQ-023 States: NORMAL (EXL=0) and HANDLER (EXL=1); NORMAL->HANDLER on int_req; HANDLER->NORMAL on eret_m & m_valid; mtc0 to SR may also change EXL.
REQ-024 In HANDLER, exc_m and interrupts SHALL be ignored (no nesting, EPC preserved).
REQ-025 eret_m with m_valid in HANDLER clears EXL at the edge; int_req stays 0 that cycle; a pending interrupt is taken no earlier than the next cycle.
REQ-026 eret_m in NORMAL SHALL be a no-op.
REQ-027 mtc0 (we=1): SR writes IM, EXL, IE; Cause writes nothing (IP, ExcCode, BD hardware-owned); EPC stores {wdata[31:2],2'b00}; PRId and other addresses ignored.
REQ-028 Simultaneous int_req and we: int_req updates win for EXL/EPC/Cause; SR.IM/IE from mtc0 still apply.
REQ-029 Simultaneous eret_m and we to SR: mtc0 value of EXL wins.
REQ-030 rdata returns register at raddr per REQ-017; unmapped addresses read 0; a same-cycle write is not bypassed.
REQ-031 epc and exl SHALL be direct register outputs.

Reset
REQ-032 reset=0: SR=0 (IE=0, EXL=0, IM=0), Cause=0, EPC=0; int_req=0 while reset asserted; state NORMAL.
REQ-033 Reset asserted mid-handler SHALL abandon HANDLER without waiting for eret.

Structure
REQ-034 Shared package cp0_pkg: register numbers 12-15, PRId value, SR/Cause bit positions, ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12).
REQ-035 One sub-module cp0_exc_prio: combinational int_pend/exc selection producing take flag and ExcCode.

Verification
REQ-036 Reset, then SR=0x0000_0401, hw_int=6'b000001, m_valid=1, pc_m=0x3010 -> int_req=1 same cycle; next cycle EXL=1, EPC=0x3010, ExcCode=0.
REQ-037 Same as REQ-036 but bd_m=1, pc_m=0x3014 -> EPC=0x3010, Cause[31]=1.
REQ-038 exc_m=1, exc_code_m=12, hw_int=0, pc_m=0x3020 -> EPC=0x3020, ExcCode=12; second exc_m next cycle -> int_req=0, EPC unchanged.
REQ-039 In HANDLER with hw_int still high: eret_m=1 -> int_req=0 that cycle, EXL=0 after edge, int_req=1 next cycle.
REQ-040 mtc0 EPC=0x0000_3007 -> rdata(14)=0x0000_3004; mtc0 to Cause=0xFFFF_FFFF -> Cause unchanged except IP.
REQ-041 int_req coincident with mtc0 SR=0x0000_FC01 -> EXL=1 after edge, IM=6'h3F, EPC from pc_m; reset pulse mid-handler -> all registers 0.
